// File: rtl/runahead_instruction_queue.sv
`default_nettype none
// ============================================================================
// Module      : runahead_instruction_queue
// Description : Captures runahead-tagged instructions during a long-latency
//               event, then replays them in order into the fetch/runahead mux.
// Revision    : 1.0 - initial release
// ============================================================================
module runahead_instruction_queue #(
    parameter int DEPTH   = 8,
    parameter int INSTR_W = 16,
    parameter int CNT_W   = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               async_rst_n,
    input  logic               flush,
    input  logic               runahead_enter,
    input  logic               runahead_release,
    input  logic               capture_valid,
    input  logic [INSTR_W-1:0] capture_instruction,
    output logic               capture_ready,
    input  logic               pipeline_ready,
    output logic               runahead_valid,
    output logic [INSTR_W-1:0] runahead_instruction,
    output logic               runahead_active,
    output logic [CNT_W-1:0]   occupancy,
    output logic               overflow_drop
);

    localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);
    localparam logic [PTR_W-1:0] ONE_PTR  = PTR_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   occ_q, occ_d;
    logic [INSTR_W-1:0] mem_q [DEPTH];

    logic is_full;
    logic is_empty;
    logic push;
    logic pop;

    // Head data is gated by valid so the unreset array never leaks X.
    always_comb begin
        is_full              = (occ_q == FULL_CNT);
        is_empty             = (occ_q == '0);
        capture_ready        = (state_q == ST_FILL) && !is_full;
        runahead_valid       = (state_q == ST_DRAIN) && !is_empty;
        runahead_instruction = runahead_valid ? mem_q[rd_ptr_q] : '0;
        runahead_active      = (state_q != ST_IDLE);
        occupancy            = occ_q;
        overflow_drop        = (state_q == ST_FILL) && is_full && capture_valid && !flush;
        push                 = capture_ready && capture_valid && !flush;
        pop                  = runahead_valid && pipeline_ready && !flush;
    end

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (flush) begin
            state_d  = ST_IDLE;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + ONE_PTR;
                occ_d    = occ_q + ONE_CNT;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + ONE_PTR;
                occ_d    = occ_q - ONE_CNT;
            end
            case (state_q)
                ST_IDLE: begin
                    if (runahead_enter) begin
                        state_d = ST_FILL;
                    end
                end
                ST_FILL: begin
                    // A push coincident with release still counts toward replay.
                    if (runahead_release) begin
                        state_d = (occ_d == '0) ? ST_IDLE : ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (pop && (occ_q == ONE_CNT)) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            state_q  <= ST_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= capture_instruction;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_runahead_instruction_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_runahead_instruction_queue
// Description : Directed and random stimulus against a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_runahead_instruction_queue;

    localparam int DEPTH   = 8;
    localparam int INSTR_W = 16;
    localparam int CNT_W   = $clog2(DEPTH) + 1;

    localparam int M_IDLE  = 0;
    localparam int M_FILL  = 1;
    localparam int M_DRAIN = 2;

    logic               clk = 1'b0;
    logic               async_rst_n = 1'b0;
    logic               flush = 1'b0;
    logic               runahead_enter = 1'b0;
    logic               runahead_release = 1'b0;
    logic               capture_valid = 1'b0;
    logic [INSTR_W-1:0] capture_instruction = '0;
    logic               capture_ready;
    logic               pipeline_ready = 1'b0;
    logic               runahead_valid;
    logic [INSTR_W-1:0] runahead_instruction;
    logic               runahead_active;
    logic [CNT_W-1:0]   occupancy;
    logic               overflow_drop;

    runahead_instruction_queue #(
        .DEPTH   (DEPTH),
        .INSTR_W (INSTR_W)
    ) u_dut (
        .clk                  (clk),
        .async_rst_n          (async_rst_n),
        .flush                (flush),
        .runahead_enter       (runahead_enter),
        .runahead_release     (runahead_release),
        .capture_valid        (capture_valid),
        .capture_instruction  (capture_instruction),
        .capture_ready        (capture_ready),
        .pipeline_ready       (pipeline_ready),
        .runahead_valid       (runahead_valid),
        .runahead_instruction (runahead_instruction),
        .runahead_active      (runahead_active),
        .occupancy            (occupancy),
        .overflow_drop        (overflow_drop)
    );

    always #5 clk = ~clk;

    int                 n_tests = 0;
    int                 n_fail  = 0;
    int                 mode    = M_IDLE;
    logic [INSTR_W-1:0] model_q[$];
    int                 valid_seen = 0;
    int                 drop_seen  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        int   sz;
        logic exp_valid;
        sz        = model_q.size();
        exp_valid = (mode == M_DRAIN) && (sz != 0);
        check_eq("capture_ready", 32'(capture_ready), 32'((mode == M_FILL) && (sz != DEPTH)));
        check_eq("runahead_valid", 32'(runahead_valid), 32'(exp_valid));
        check_eq("runahead_instruction", 32'(runahead_instruction),
                 exp_valid ? 32'(model_q[0]) : 32'h0);
        check_eq("runahead_active", 32'(runahead_active), 32'(mode != M_IDLE));
        check_eq("occupancy", 32'(occupancy), 32'(sz));
        check_eq("overflow_drop", 32'(overflow_drop),
                 32'((mode == M_FILL) && (sz == DEPTH) && capture_valid && !flush));
        if (runahead_valid) valid_seen++;
        if (overflow_drop) drop_seen++;
    endtask

    task automatic model_update();
        if (flush) begin
            model_q.delete();
            mode = M_IDLE;
        end else begin
            case (mode)
                M_IDLE: if (runahead_enter) mode = M_FILL;
                M_FILL: begin
                    if (capture_valid && model_q.size() < DEPTH) model_q.push_back(capture_instruction);
                    if (runahead_release) mode = (model_q.size() != 0) ? M_DRAIN : M_IDLE;
                end
                default: begin
                    if (pipeline_ready && model_q.size() != 0) begin
                        void'(model_q.pop_front());
                        if (model_q.size() == 0) mode = M_IDLE;
                    end
                end
            endcase
        end
    endtask

    task automatic drive(input logic en, input logic rel, input logic cv,
                         input logic [INSTR_W-1:0] ci, input logic pr, input logic fl);
        runahead_enter      = en;
        runahead_release    = rel;
        capture_valid       = cv;
        capture_instruction = ci;
        pipeline_ready      = pr;
        flush               = fl;
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_update();
        #1;
        runahead_enter   = 1'b0;
        runahead_release = 1'b0;
        capture_valid    = 1'b0;
        pipeline_ready   = 1'b0;
        flush            = 1'b0;
    endtask

    task automatic apply_reset();
        #2;
        async_rst_n = 1'b0;
        #1;
        check_eq("rst_valid", 32'(runahead_valid), 32'h0);
        check_eq("rst_occupancy", 32'(occupancy), 32'h0);
        check_eq("rst_active", 32'(runahead_active), 32'h0);
        check_eq("rst_instr", 32'(runahead_instruction), 32'h0);
        model_q.delete();
        mode = M_IDLE;
        @(negedge clk);
        async_rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic drain_all();
        for (int i = 0; i < 40; i++) begin
            if (mode == M_IDLE) break;
            drive(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
        end
        check_eq("drain_to_idle", 32'(runahead_active), 32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [INSTR_W-1:0] vals[3];
        logic               rp[5];
        vals = '{16'h1111, 16'h2222, 16'h3333};
        rp   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

        @(posedge clk);
        #1;
        apply_reset();

        // Test 2: basic capture and ordered replay
        drive(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b1, vals[i], 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        valid_seen = 0;
        drain_all();
        check_eq("t2_valid_cycles", 32'(valid_seen), 32'd3);

        // Test 1: async reset mid-DRAIN with 3 entries held
        drive(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b1, 16'hA000 + 16'(i), 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        check_eq("t1_pre_occ", 32'(occupancy), 32'd3);
        apply_reset();
        drive(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0);

        // Test 3: overflow at DEPTH
        drive(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        drop_seen = 0;
        for (int i = 0; i < DEPTH + 1; i++) drive(1'b0, 1'b0, 1'b1, 16'hB000 + 16'(i), 1'b0, 1'b0);
        check_eq("t3_drop_count", 32'(drop_seen), 32'd1);
        check_eq("t3_occupancy", 32'(occupancy), 32'(DEPTH));
        check_eq("t3_ready", 32'(capture_ready), 32'h0);

        // Test 4: stalled replay
        drive(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 1'b0, '0, rp[i], 1'b0);
        check_eq("t4_occupancy", 32'(occupancy), 32'(DEPTH - 3));
        drain_all();

        // Test 5: flush beats push and pop
        drive(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 16'hC001, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 16'hC002, 1'b0, 1'b1);
        check_eq("t5_fill_flush_occ", 32'(occupancy), 32'h0);
        check_eq("t5_fill_flush_active", 32'(runahead_active), 32'h0);
        drive(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 16'hC003, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 16'hC004, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b1);
        check_eq("t5_drain_flush_occ", 32'(occupancy), 32'h0);
        check_eq("t5_drain_flush_active", 32'(runahead_active), 32'h0);

        // Test 6: pointer wrap over three fill/drain rounds
        for (int r = 0; r < 3; r++) begin
            drive(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
            for (int i = 0; i < 6; i++) drive(1'b0, 1'b0, 1'b1, 16'(16'hD000 + r * 16 + i), 1'b0, 1'b0);
            drive(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
            valid_seen = 0;
            drain_all();
            check_eq("t6_round_pops", 32'(valid_seen), 32'd6);
        end

        // Release with an empty queue goes straight to IDLE
        valid_seen = 0;
        drive(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
        check_eq("t6_empty_release_valid", 32'(valid_seen), 32'h0);
        check_eq("t6_empty_release_active", 32'(runahead_active), 32'h0);

        // Random phase
        for (int n = 0; n < 1500; n++) begin
            logic en, rel, cv, pr, fl;
            en  = ($urandom_range(0, 7) == 0);
            rel = ($urandom_range(0, 9) == 0);
            cv  = ($urandom_range(0, 1) == 1);
            pr  = ($urandom_range(0, 2) != 0);
            fl  = ($urandom_range(0, 59) == 0);
            if (rel && mode == M_FILL && model_q.size() == 0) cv = 1'b0;
            drive(en, rel, cv, 16'($urandom), pr, fl);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
